regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 = ALU/execute result, req1 = load-unit return.
- Tracks a busy scoreboard of destination registers with writes still pending.
- Gives decode a combinational hazard flag.
- Sits between execute/LSU writeback and the 32x32 regfile; drives the regfile write_enable/write_idx/write_data inputs from registers.

---
 rtl/rv_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file writeback constants: widths, the hardwired zero index and requester IDs.
// No logic; latency n/a.
// Backpressure n/a.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int IDX_W = 5;

    localparam logic [IDX_W-1:0] REG_ZERO = '0;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per destination register plus the decode hazard compare.
// Set/clear take effect at the clock edge; hazard is combinational from the registered bits.
// No backpressure: set and clear are accepted every cycle.
module regfile_scoreboard #(
    parameter int IDX_W = rv_pkg::IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [IDX_W-1:0]      set_idx,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_idx,
    input  logic [IDX_W-1:0]      rs1,
    input  logic [IDX_W-1:0]      rs2,
    input  logic [IDX_W-1:0]      rd,
    output logic                  hazard,
    output logic [(1<<IDX_W)-1:0] busy_mask
);
    localparam int NREG = 1 << IDX_W;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // Set is applied after clear: a newly issued producer overrides the retiring one.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // busy[0] is pinned low, so x0 never raises a hazard.
    assign hazard    = busy[rs1] | busy[rs2] | busy[rd];
    assign busy_mask = busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (req0) and LSU (req1) writebacks onto the single regfile write port, round-robin on contention.
// Latency 1: a transfer in cycle T appears on rf_we/rf_widx/rf_wdata in cycle T+1.
// Ready is a combinational grant, at most one per cycle; the regfile never stalls, so throughput is 1 write/cycle.
module regfile_wb_arbiter #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int IDX_W = rv_pkg::IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [IDX_W-1:0]      issue_rd,
    input  logic [IDX_W-1:0]      chk_rs1,
    input  logic [IDX_W-1:0]      chk_rs2,
    input  logic [IDX_W-1:0]      chk_rd,
    output logic                  hazard,
    input  logic                  req0_valid,
    input  logic [IDX_W-1:0]      req0_idx,
    input  logic [XLEN-1:0]       req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [IDX_W-1:0]      req1_idx,
    input  logic [XLEN-1:0]       req1_data,
    output logic                  req1_ready,
    output logic                  rf_we,
    output logic [IDX_W-1:0]      rf_widx,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [(1<<IDX_W)-1:0] busy_mask
);
    import rv_pkg::*;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  data;
    } wb_req_t;

    logic    last_grant;
    logic    gnt0;
    logic    gnt1;
    logic    xfer;
    logic    wr_en_next;
    wb_req_t sel;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                if (last_grant == REQ_LSU) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign sel        = gnt1 ? wb_req_t'{idx: req1_idx, data: req1_data}
                             : wb_req_t'{idx: req0_idx, data: req0_data};
    // x0 writes complete the handshake but are dropped here.
    assign wr_en_next = xfer && (sel.idx != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_widx    <= '0;
            rf_wdata   <= '0;
            last_grant <= REQ_LSU;
        end else begin
            rf_we <= wr_en_next;
            if (wr_en_next) begin
                rf_widx  <= sel.idx;
                rf_wdata <= sel.data;
            end
            if (xfer) begin
                last_grant <= gnt1 ? REQ_LSU : REQ_ALU;
            end
        end
    end

    // Busy clears on the edge that commits the write into the regfile.
    regfile_scoreboard #(
        .IDX_W (IDX_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (issue_valid && (issue_rd != REG_ZERO)),
        .set_idx   (issue_rd),
        .clr_en    (rf_we),
        .clr_idx   (rf_widx),
        .rs1       (chk_rs1),
        .rs2       (chk_rs2),
        .rd        (chk_rd),
        .hazard    (hazard),
        .busy_mask (busy_mask)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic checked against a cycle-level reference model of the writeback arbiter.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_idx, req1_idx;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_widx;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: which registers await a write, the pending regfile write, and who won last.
    bit          m_busy [32];
    bit          m_last;
    bit          m_we;
    logic [4:0]  m_widx;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .hazard      (hazard),
        .req0_valid  (req0_valid),
        .req0_idx    (req0_idx),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_idx    (req1_idx),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_we       (rf_we),
        .rf_widx     (rf_widx),
        .rf_wdata    (rf_wdata),
        .busy_mask   (busy_mask)
    );

    function automatic int winner();
        if (rst) return -1;
        if (req0_valid && req1_valid) return m_last ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic exp_hazard();
        return (chk_rs1 != 0 && m_busy[chk_rs1]) || (chk_rs2 != 0 && m_busy[chk_rs2]) ||
               (chk_rd != 0 && m_busy[chk_rd]);
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_busy[i];
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_step();
        int w;
        logic [4:0] idx;
        w = winner();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_we = 1'b0; m_widx = '0; m_wdata = '0; m_last = 1'b1;
        end else begin
            if (m_we) m_busy[m_widx] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            m_we = 1'b0;
            if (w >= 0) begin
                m_last = (w == 1);
                idx = (w == 1) ? req1_idx : req0_idx;
                if (idx != 0) begin
                    m_we    = 1'b1;
                    m_widx  = idx;
                    m_wdata = (w == 1) ? req1_data : req0_data;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        req0_valid = 0; req0_idx = 0; req0_data = 0;
        req1_valid = 0; req1_idx = 0; req1_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; req0_valid = 1; req0_idx = 3;
        #1;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0: got %0b want 0", req0_ready); else n_pass++;
        cycle(); cycle();
        rst = 0; req0_valid = 0;
        chk_rs1 = 5; chk_rs2 = 5; chk_rd = 5;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_widx !== 5'd0) $display("FAIL reset_widx: got %0d want 0", rf_widx); else n_pass++;
        n_checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", rf_wdata); else n_pass++;
        n_checks++; if (busy_mask !== 32'd0) $display("FAIL reset_busy: got %h want 0", busy_mask); else n_pass++;
        n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard: got %0b want 0", hazard); else n_pass++;
        cycle();
    endtask

    task automatic test_alternate();
        clear_inputs();
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1; req0_idx = 3; req0_data = 32'(100 + k);
            req1_valid = 1; req1_idx = 4; req1_data = 32'(200 + k);
            #1;
            n_checks++; if (req0_ready !== ((k % 2) == 0)) $display("FAIL alt_ready0[%0d]: got %0b", k, req0_ready); else n_pass++;
            n_checks++; if (req1_ready !== ((k % 2) == 1)) $display("FAIL alt_ready1[%0d]: got %0b", k, req1_ready); else n_pass++;
            if (k > 0) begin
                n_checks++; if (rf_we !== 1'b1) $display("FAIL alt_we[%0d]: got %0b want 1", k, rf_we); else n_pass++;
                n_checks++; if (rf_widx !== ((k % 2) == 1 ? 5'd3 : 5'd4)) $display("FAIL alt_widx[%0d]: got %0d", k, rf_widx); else n_pass++;
            end
            cycle();
        end
        clear_inputs();
        #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL alt_last_we: got %0b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_wdata !== 32'd203) $display("FAIL alt_last_wdata: got %0d want 203", rf_wdata); else n_pass++;
        cycle();
    endtask

    task automatic test_issue_write();
        clear_inputs();
        issue_valid = 1; issue_rd = 7;
        cycle();
        issue_valid = 0; chk_rs1 = 7;
        #1;
        n_checks++; if (busy_mask[7] !== 1'b1) $display("FAIL iw_busy_set: got %0b want 1", busy_mask[7]); else n_pass++;
        n_checks++; if (hazard !== 1'b1) $display("FAIL iw_hazard: got %0b want 1", hazard); else n_pass++;
        cycle(); cycle();
        req0_valid = 1; req0_idx = 7; req0_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL iw_ready0: got %0b want 1", req0_ready); else n_pass++;
        cycle();
        req0_valid = 0;
        #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL iw_we: got %0b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_widx !== 5'd7) $display("FAIL iw_widx: got %0d want 7", rf_widx); else n_pass++;
        n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL iw_wdata: got %h want deadbeef", rf_wdata); else n_pass++;
        n_checks++; if (busy_mask[7] !== 1'b1) $display("FAIL iw_busy_T4: got %0b want 1", busy_mask[7]); else n_pass++;
        cycle();
        n_checks++; if (busy_mask[7] !== 1'b0) $display("FAIL iw_busy_clr: got %0b want 0", busy_mask[7]); else n_pass++;
        n_checks++; if (hazard !== 1'b0) $display("FAIL iw_hazard_clr: got %0b want 0", hazard); else n_pass++;
    endtask

    task automatic test_set_wins();
        clear_inputs();
        issue_valid = 1; issue_rd = 9;
        req0_valid = 1; req0_idx = 9; req0_data = 32'h0000_0909;
        cycle();
        req0_valid = 0; issue_valid = 1; issue_rd = 9;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_widx !== 5'd9) $display("FAIL sw_commit: got we=%0b idx=%0d want 1/9", rf_we, rf_widx); else n_pass++;
        cycle();
        issue_valid = 0;
        #1;
        n_checks++; if (busy_mask[9] !== 1'b1) $display("FAIL sw_set_wins: got %0b want 1", busy_mask[9]); else n_pass++;
        cycle();
    endtask

    task automatic test_x0();
        logic [31:0] snap;
        clear_inputs();
        snap = exp_mask();
        req1_valid = 1; req1_idx = 0; req1_data = 32'h1234;
        #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL x0_ready1: got %0b want 1", req1_ready); else n_pass++;
        cycle();
        req1_valid = 0;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL x0_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (busy_mask !== snap) $display("FAIL x0_busy: got %h want %h", busy_mask, snap); else n_pass++;
        cycle();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        issue_valid = 1; issue_rd = 5;
        req0_valid = 1; req0_idx = 5; req0_data = 32'h55;
        cycle();
        issue_valid = 0; rst = 1; req0_idx = 6; req0_data = 32'h66;
        #1;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL rm_ready_in_rst: got %0b want 0", req0_ready); else n_pass++;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL rm_we_before: got %0b want 1", rf_we); else n_pass++;
        cycle();
        rst = 0;
        req0_valid = 1; req0_idx = 3; req0_data = 32'h33;
        req1_valid = 1; req1_idx = 4; req1_data = 32'h44;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rm_we_after: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (busy_mask !== 32'd0) $display("FAIL rm_busy_after: got %h want 0", busy_mask); else n_pass++;
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL rm_first_grant: got r0=%0b r1=%0b want 1/0", req0_ready, req1_ready); else n_pass++;
        cycle();
        clear_inputs();
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_widx !== 5'd3) $display("FAIL rm_commit: got we=%0b idx=%0d want 1/3", rf_we, rf_widx); else n_pass++;
        cycle();
    endtask

    task automatic test_random();
        bit hold0 = 0, hold1 = 0;
        int w;
        clear_inputs();
        for (int n = 0; n < 400; n++) begin
            if (!hold0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_idx = 5'($urandom_range(0, 31)); req0_data = $urandom;
            end
            if (!hold1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_idx = 5'($urandom_range(0, 31)); req1_data = $urandom;
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = 5'($urandom_range(0, 31));
            chk_rd  = 5'($urandom_range(0, 31));
            #1;
            w = winner();
            n_checks++; if (req0_ready !== (w == 0)) $display("FAIL rnd_ready0[%0d]: got %0b want %0b", n, req0_ready, w == 0); else n_pass++;
            n_checks++; if (req1_ready !== (w == 1)) $display("FAIL rnd_ready1[%0d]: got %0b want %0b", n, req1_ready, w == 1); else n_pass++;
            n_checks++; if (hazard !== exp_hazard()) $display("FAIL rnd_hazard[%0d]: got %0b want %0b", n, hazard, exp_hazard()); else n_pass++;
            n_checks++; if (busy_mask !== exp_mask()) $display("FAIL rnd_busy[%0d]: got %h want %h", n, busy_mask, exp_mask()); else n_pass++;
            n_checks++; if (rf_we !== m_we) $display("FAIL rnd_we[%0d]: got %0b want %0b", n, rf_we, m_we); else n_pass++;
            if (m_we) begin
                n_checks++;
                if (rf_widx !== m_widx || rf_wdata !== m_wdata)
                    $display("FAIL rnd_write[%0d]: got %0d/%h want %0d/%h", n, rf_widx, rf_wdata, m_widx, m_wdata);
                else n_pass++;
            end
            hold0 = req0_valid && (w != 0);
            hold1 = req1_valid && (w != 1);
            cycle();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_alternate();
        test_issue_write();
        test_set_wins();
        test_x0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
